// File: rtl/instruction_sequencer.sv
// instruction_sequencer: fetches 32-bit instructions, decodes the opcode and dispatches
// commands to the matrix or integer ALU. Define WATCHDOG_EN to add a WAIT_DONE timeout.
module instruction_sequencer #(
  parameter logic [3:0] IMEM_SEL    = 4'h1,
  parameter logic [3:0] MATRIX_SEL  = 4'h2,
  parameter logic [3:0] INT_SEL     = 4'h3,
  parameter int         IMEM_DEPTH  = 10,
  parameter int         FETCH_LAT   = 1,
  parameter int         TIMEOUT_CYC = 255
) (
  input  logic        Clk,
  input  logic        nReset,
  input  logic        start,
  output logic [15:0] imem_addr,
  output logic        imem_nRead,
  input  logic [31:0] imem_data,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [3:0]  cmd_unit,
  output logic [7:0]  cmd_opcode,
  output logic [7:0]  cmd_dest,
  output logic [7:0]  cmd_src1,
  output logic [7:0]  cmd_src2,
  input  logic        done_in,
  output logic [11:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        fault,
  output logic [1:0]  fault_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT_DATA,
    S_DECODE,
    S_ISSUE,
    S_WAIT_DONE,
    S_HALT,
    S_FAULT
  } state_t;

  localparam logic [3:0]  LAT_INIT = 4'(FETCH_LAT);
  localparam logic [11:0] LAST_PC  = 12'(IMEM_DEPTH - 1);

  state_t      state;
  state_t      state_nx;
  logic [31:0] ir;
  logic [3:0]  lat_cnt;
  logic [7:0]  op;
  logic        lat_done;
  logic        is_mat;
  logic        is_int;
  logic        is_stop;
  logic        wd_expire;

  assign op       = ir[31:24];
  assign is_mat   = (op <= 8'h05);
  assign is_int   = (op >= 8'h10) && (op <= 8'h13);
  assign is_stop  = (op == 8'hFF);
  // Capture happens on the edge where the counter steps down to zero.
  assign lat_done = (lat_cnt <= 4'd1);

`ifdef WATCHDOG_EN
  localparam logic [7:0] WD_LAST = 8'(TIMEOUT_CYC - 1);
  logic [7:0] wd_cnt;

  // Held at zero while issuing so it reads zero on the first WAIT_DONE cycle.
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      wd_cnt <= '0;
    end else if (state == S_ISSUE) begin
      wd_cnt <= '0;
    end else if (state == S_WAIT_DONE) begin
      wd_cnt <= wd_cnt + 8'd1;
    end
  end

  assign wd_expire = (wd_cnt == WD_LAST);
`else
  logic [7:0] unused_timeout;
  assign unused_timeout = 8'(TIMEOUT_CYC);
  assign wd_expire      = 1'b0;
`endif

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    imem_addr  = 16'h0000;
    imem_nRead = 1'b1;
    busy       = 1'b1;
    halted     = 1'b0;
    fault      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nx = S_FETCH;
      end
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (start) state_nx = S_FETCH;
      end
      S_FAULT: begin
        busy  = 1'b0;
        fault = 1'b1;
        if (start) state_nx = S_FETCH;
      end
      S_FETCH: begin
        imem_nRead = 1'b0;
        imem_addr  = {IMEM_SEL, pc};
        state_nx   = S_WAIT_DATA;
      end
      S_WAIT_DATA: begin
        if (lat_done) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (is_mat || is_int) state_nx = S_ISSUE;
        else if (is_stop)     state_nx = S_HALT;
        else                  state_nx = S_FAULT;
      end
      S_ISSUE: begin
        if (cmd_ready) state_nx = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        // done_in has priority over a watchdog expiry on the same cycle.
        if (done_in)        state_nx = (pc == LAST_PC) ? S_FAULT : S_FETCH;
        else if (wd_expire) state_nx = S_FAULT;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      pc         <= '0;
      ir         <= '0;
      lat_cnt    <= '0;
      fault_code <= 2'd0;
      cmd_valid  <= 1'b0;
      cmd_unit   <= '0;
      cmd_opcode <= '0;
      cmd_dest   <= '0;
      cmd_src1   <= '0;
      cmd_src2   <= '0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_FAULT: begin
          if (start) begin
            pc         <= '0;
            fault_code <= 2'd0;
          end
        end
        S_FETCH: begin
          lat_cnt <= LAT_INIT;
        end
        S_WAIT_DATA: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_done) ir <= imem_data;
        end
        S_DECODE: begin
          if (is_mat || is_int) begin
            cmd_valid  <= 1'b1;
            cmd_unit   <= is_mat ? MATRIX_SEL : INT_SEL;
            cmd_opcode <= ir[31:24];
            cmd_dest   <= ir[23:16];
            cmd_src1   <= ir[15:8];
            cmd_src2   <= ir[7:0];
          end else if (!is_stop) begin
            fault_code <= 2'd1;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid  <= 1'b0;
            cmd_unit   <= '0;
            cmd_opcode <= '0;
            cmd_dest   <= '0;
            cmd_src1   <= '0;
            cmd_src2   <= '0;
          end
        end
        S_WAIT_DONE: begin
          if (done_in) begin
            if (pc == LAST_PC) fault_code <= 2'd2;
            else               pc <= pc + 12'd1;
          end else if (wd_expire) begin
            fault_code <= 2'd3;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed programs plus randomized
// programs and ALU timing, checked against a program-level reference model.
`timescale 1ns/1ps
module tb_instruction_sequencer;

  localparam int DEPTH = 10;

  logic        Clk = 1'b0;
  logic        nReset;
  logic        start;
  logic [15:0] imem_addr;
  logic        imem_nRead;
  logic [31:0] imem_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_unit;
  logic [7:0]  cmd_opcode;
  logic [7:0]  cmd_dest;
  logic [7:0]  cmd_src1;
  logic [7:0]  cmd_src2;
  logic        done_in;
  logic [11:0] pc;
  logic        busy;
  logic        halted;
  logic        fault;
  logic [1:0]  fault_code;

  logic [31:0] prog [0:DEPTH-1];
  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  instruction_sequencer #(
    .IMEM_DEPTH (DEPTH),
    .TIMEOUT_CYC(20)
  ) dut (
    .Clk       (Clk),
    .nReset    (nReset),
    .start     (start),
    .imem_addr (imem_addr),
    .imem_nRead(imem_nRead),
    .imem_data (imem_data),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_unit  (cmd_unit),
    .cmd_opcode(cmd_opcode),
    .cmd_dest  (cmd_dest),
    .cmd_src1  (cmd_src1),
    .cmd_src2  (cmd_src2),
    .done_in   (done_in),
    .pc        (pc),
    .busy      (busy),
    .halted    (halted),
    .fault     (fault),
    .fault_code(fault_code)
  );

  // Instruction memory: one cycle after a read strobe the word appears; junk until then.
  initial begin : imem_model
    bit          pend;
    logic [11:0] paddr;
    pend      = 1'b0;
    paddr     = '0;
    imem_data = '0;
    forever begin
      @(negedge Clk);
      if (pend) begin
        imem_data = (int'(paddr) < DEPTH) ? prog[int'(paddr)] : 32'hFFFF_FFFF;
        pend      = 1'b0;
      end
      if (nReset === 1'b1 && imem_nRead === 1'b0) begin
        paddr     = imem_addr[11:0];
        pend      = 1'b1;
        imem_data = $urandom();
      end
    end
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Runs the program in prog[] from a start pulse, acting as the ALU.
  // rdly<0: random ready delay; ddly==0: random done delay; commands beyond done_limit never complete.
  task automatic run_prog(input int rdly, input int ddly, input int done_limit, input bit glitch,
                          input int max_cyc, input bit expect_end,
                          output int hs_cnt, output int vcyc, output int age);
    logic [35:0] expq [$];
    logic [35:0] held;
    logic [35:0] got;
    logic [7:0]  op;
    logic        exp_halt;
    logic [1:0]  exp_fc;
    int          exp_pc;
    int          n_exp;
    int          fetch_n;
    int          cyc;
    int          rcnt;
    int          rneed;
    int          dcnt;
    bit          vprev;
    bit          ended;

    exp_halt = 1'b0;
    exp_fc   = 2'd0;
    exp_pc   = 0;
    for (int k = 0; k < DEPTH; k++) begin
      op = prog[k][31:24];
      if (op == 8'hFF) begin
        exp_halt = 1'b1;
        exp_pc   = k;
        break;
      end
      if (op > 8'h05 && !(op >= 8'h10 && op <= 8'h13)) begin
        exp_fc = 2'd1;
        exp_pc = k;
        break;
      end
      expq.push_back({(op <= 8'h05) ? 4'h2 : 4'h3, prog[k]});
      if (k == DEPTH - 1) begin
        exp_fc = 2'd2;
        exp_pc = k;
      end
    end
    n_exp = expq.size();

    hs_cnt = 0; vcyc = 0; age = 0; fetch_n = 0; cyc = 0;
    rcnt = 0; rneed = 0; dcnt = -1; vprev = 1'b0; ended = 1'b0; held = '0;
    cmd_ready = 1'b0;
    done_in   = 1'b0;
    start     = 1'b1;
    while (cyc < max_cyc) begin
      @(negedge Clk);
      cyc++;
      start   = 1'b0;
      done_in = 1'b0;
      if (age > 0) age++;
      if (imem_nRead === 1'b0) begin
        chk("fetch_addr", 36'(imem_addr), 36'(16'h1000 + fetch_n));
        fetch_n++;
      end
      if (cmd_ready && vprev) begin
        hs_cnt++;
        age       = 1;
        cmd_ready = 1'b0;
        chk("valid_drop", 36'(cmd_valid), 36'd0);
        if (expq.size() == 0) chk("cmd_count_ovf", 36'(hs_cnt), 36'(n_exp));
        else                  chk("cmd", held, expq.pop_front());
        if (hs_cnt > done_limit) dcnt = -1;
        else                     dcnt = (ddly == 0) ? int'($urandom_range(1, 6)) : ddly;
      end else if (cmd_valid === 1'b1) begin
        got = {cmd_unit, cmd_opcode, cmd_dest, cmd_src1, cmd_src2};
        vcyc++;
        if (!vprev) begin
          held  = got;
          rcnt  = 0;
          rneed = (rdly < 0) ? int'($urandom_range(0, 4)) : rdly;
        end else begin
          chk("cmd_stable", got, held);
        end
        if (rcnt >= rneed) begin
          cmd_ready = 1'b1;
          if (glitch && $urandom_range(0, 1) == 1) done_in = 1'b1;
        end else begin
          cmd_ready = 1'b0;
        end
        rcnt++;
      end else begin
        cmd_ready = (rdly < 0) ? ($urandom_range(0, 5) == 0) : 1'b0;
      end
      vprev = (cmd_valid === 1'b1);
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          done_in = 1'b1;
          dcnt    = -1;
        end
      end
      if (busy === 1'b0) begin
        ended = 1'b1;
        break;
      end
    end
    cmd_ready = 1'b0;
    done_in   = 1'b0;

    if (expect_end) begin
      chk("end_reached", 36'(ended), 36'd1);
      chk("halted", 36'(halted), 36'(exp_halt));
      chk("fault", 36'(fault), 36'(exp_fc != 2'd0));
      chk("fault_code", 36'(fault_code), 36'(exp_fc));
      chk("pc", 36'(pc), 36'(exp_pc));
      chk("busy_end", 36'(busy), 36'd0);
      chk("cmd_total", 36'(hs_cnt), 36'(n_exp));
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_nread"}, 36'(imem_nRead), 36'd1);
    chk({tag, "_addr"}, 36'(imem_addr), 36'd0);
    chk({tag, "_valid"}, 36'(cmd_valid), 36'd0);
    chk({tag, "_fields"}, {cmd_unit, cmd_opcode, cmd_dest, cmd_src1, cmd_src2}, 36'd0);
    chk({tag, "_pc"}, 36'(pc), 36'd0);
    chk({tag, "_status"}, 36'({busy, halted, fault, fault_code}), 36'd0);
  endtask

  initial begin
    int         hs;
    int         vc;
    int         ag;
    int         sel;
    logic [7:0] op;

    for (int k = 0; k < DEPTH; k++) prog[k] = '0;
    nReset    = 1'b0;
    start     = 1'b0;
    cmd_ready = 1'b0;
    done_in   = 1'b0;
    @(negedge Clk);
    chk_reset_outputs("reset");
    nReset = 1'b1;
    @(negedge Clk);
    chk("idle_busy", 36'(busy), 36'd0);

    // Integer op then STOP; ALU ready at once, done 3 cycles after handshake.
    prog[0] = 32'h10_02_00_01;
    prog[1] = 32'hFF_00_00_00;
    run_prog(0, 3, 99, 1'b0, 500, 1'b1, hs, vc, ag);
    chk("tp1_hs", 36'(hs), 36'd1);

    // Matrix op with ready held low for 5 cycles.
    prog[0] = 32'h04_05_03_80;
    run_prog(5, 2, 99, 1'b0, 500, 1'b1, hs, vc, ag);
    chk("stall_valid_cycles", 36'(vc), 36'd6);

    // Illegal opcode: no command may be offered.
    prog[0] = 32'h07_00_00_00;
    run_prog(0, 1, 99, 1'b0, 500, 1'b1, hs, vc, ag);
    chk("illegal_no_valid", 36'(vc), 36'd0);

    // No STOP word: running past the last word faults with pc held.
    for (int k = 0; k < DEPTH; k++) prog[k] = {(k % 2 == 0) ? 8'h13 : 8'h00, 24'($urandom())};
    run_prog(-1, 0, 99, 1'b1, 1000, 1'b1, hs, vc, ag);

    // Randomized programs and ALU timing.
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        sel = int'($urandom_range(0, 19));
        if (sel < 9)        op = 8'($urandom_range(0, 5));
        else if (sel < 18)  op = 8'($urandom_range(16, 19));
        else if (sel == 18) op = 8'hFF;
        else                op = 8'($urandom_range(20, 254));
        prog[k] = {op, 24'($urandom())};
      end
      run_prog(-1, 0, 99, 1'b1, 1000, 1'b1, hs, vc, ag);
    end

    // Reset while waiting on the second instruction's completion.
    for (int k = 0; k < DEPTH; k++) prog[k] = 32'hFF_00_00_00;
    prog[0] = 32'h10_01_02_03;
    prog[1] = 32'h11_04_05_06;
    run_prog(0, 2, 1, 1'b0, 40, 1'b0, hs, vc, ag);
    chk("pre_reset_pc", 36'(pc), 36'd1);
    chk("pre_reset_busy", 36'(busy), 36'd1);
    #2 nReset = 1'b0;
    #1 chk_reset_outputs("async_reset");
    @(negedge Clk);
    nReset = 1'b1;
    @(negedge Clk);
    run_prog(0, 2, 99, 1'b0, 500, 1'b1, hs, vc, ag);

    // ALU never reports completion.
    prog[0] = 32'h10_02_00_01;
    prog[1] = 32'hFF_00_00_00;
`ifdef WATCHDOG_EN
    run_prog(0, 1, 0, 1'b0, 200, 1'b0, hs, vc, ag);
    chk("wd_fault", 36'(fault), 36'd1);
    chk("wd_code", 36'(fault_code), 36'd3);
    chk("wd_latency", 36'(ag), 36'd21);
`else
    run_prog(0, 1, 0, 1'b0, 1000, 1'b0, hs, vc, ag);
    chk("nowd_busy", 36'(busy), 36'd1);
    chk("nowd_fault", 36'(fault), 36'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
